fir_input_sequencer: RTL

- Upstream stage of the FIR filter datapath.
- Holds a 4-entry coefficient register bank and buffers incoming samples in a small FIFO.
- Drives the filter's load_coeff/fir_coefficient and data_ready/sample_data handshakes, paced by the filter's modwait.
- Coefficients are always fully loaded before any sample is issued.

---
 rtl/fir_input_pkg.sv | 21 ++
 rtl/fir_input_sequencer_sample_fifo.sv | 59 +++++
 rtl/fir_input_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fir_input_pkg.sv
// Shared constants and FSM state type for the FIR input sequencer.
// The optional modwait watchdog is enabled with FIR_INPUT_TIMEOUT_EN.
package fir_input_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int NUM_COEFFS     = 4;
  localparam int COEFF_IDX_W    = $clog2(NUM_COEFFS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COEFF_REQ  = 3'd1,
    COEFF_WAIT = 3'd2,
    SAMP_REQ   = 3'd3,
    SAMP_WAIT  = 3'd4
  } state_t;

  function automatic logic is_last_coeff(input logic [COEFF_IDX_W-1:0] idx);
    return idx == COEFF_IDX_W'(NUM_COEFFS - 1);
  endfunction

endpackage

// File: rtl/fir_input_sequencer_sample_fifo.sv
// Sample FIFO: circular buffer with a count register that separates full from empty.
module sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              do_push;
  logic              do_pop;

  // full/empty come from the registered count, so a same-cycle pop never makes room
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fir_input_sequencer.sv
// Upstream FIR stage: coefficient bank, sample FIFO and the modwait-paced request FSM.
// Define FIR_INPUT_TIMEOUT_EN to add the sticky timeout output and modwait watchdog.
module fir_input_sequencer
  import fir_input_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
`ifdef FIR_INPUT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 32
`endif
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   coeff_wr,
  input  logic [COEFF_IDX_W-1:0] coeff_addr,
  input  logic [DATA_W-1:0]      coeff_wdata,
  input  logic                   coeff_start,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_in,
  output logic                   sample_ready,
  input  logic                   modwait,
  output logic                   load_coeff,
  output logic [DATA_W-1:0]      fir_coefficient,
  output logic                   data_ready,
  output logic [DATA_W-1:0]      sample_data,
  output logic                   coeff_loaded,
  output logic                   overrun,
  output state_t                 state_dbg
`ifdef FIR_INPUT_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  state_t                 state_q;
  logic [COEFF_IDX_W-1:0] idx_q;
  logic [COEFF_IDX_W-1:0] idx_nxt;
  logic                   pending_q;
  logic                   coeff_loaded_q;
  logic                   load_coeff_q;
  logic                   data_ready_q;
  logic [DATA_W-1:0]      fir_coef_q;
  logic [DATA_W-1:0]      sample_data_q;
  logic                   overrun_q;
  logic [DATA_W-1:0]      bank_q [NUM_COEFFS];

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_W-1:0]      fifo_rdata;
  logic                   start_req;

  assign start_req = coeff_start || pending_q;
  assign idx_nxt   = idx_q + COEFF_IDX_W'(1);
  assign fifo_push = sample_valid && !fifo_full;
  // A coefficient load always wins over a queued sample
  assign fifo_pop  = (state_q == IDLE) && !start_req && coeff_loaded_q && !fifo_empty;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (sample_in),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_COEFFS; i++) bank_q[i] <= '0;
    end else if (coeff_wr) begin
      bank_q[coeff_addr] <= coeff_wdata;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      overrun_q <= 1'b0;
    end else if (sample_valid && fifo_full) begin
      overrun_q <= 1'b1;
    end
  end

`ifdef FIR_INPUT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;
  logic             wait_done;

  always_comb begin
    wait_done = 1'b0;
    case (state_q)
      COEFF_REQ, SAMP_REQ:   wait_done = modwait;
      COEFF_WAIT, SAMP_WAIT: wait_done = !modwait;
      default:               wait_done = 1'b0;
    endcase
  end

  assign timeout = timeout_q;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      coeff_loaded_q <= 1'b0;
      load_coeff_q   <= 1'b0;
      data_ready_q   <= 1'b0;
      fir_coef_q     <= '0;
      sample_data_q  <= '0;
`ifdef FIR_INPUT_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      if (coeff_start && state_q != IDLE) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_req) begin
            coeff_loaded_q <= 1'b0;
            pending_q      <= 1'b0;
            idx_q          <= '0;
            fir_coef_q     <= bank_q[0];
            load_coeff_q   <= 1'b1;
            state_q        <= COEFF_REQ;
          end else if (fifo_pop) begin
            sample_data_q <= fifo_rdata;
            data_ready_q  <= 1'b1;
            state_q       <= SAMP_REQ;
          end
        end
        COEFF_REQ: begin
          if (modwait) begin
            load_coeff_q <= 1'b0;
            state_q      <= COEFF_WAIT;
          end
        end
        COEFF_WAIT: begin
          if (!modwait) begin
            if (is_last_coeff(idx_q)) begin
              coeff_loaded_q <= 1'b1;
              state_q        <= IDLE;
            end else begin
              // Snapshot here so bank writes during the load cannot disturb it
              idx_q        <= idx_nxt;
              fir_coef_q   <= bank_q[idx_nxt];
              load_coeff_q <= 1'b1;
              state_q      <= COEFF_REQ;
            end
          end
        end
        SAMP_REQ: begin
          if (modwait) begin
            data_ready_q <= 1'b0;
            state_q      <= SAMP_WAIT;
          end
        end
        SAMP_WAIT: begin
          if (!modwait) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef FIR_INPUT_TIMEOUT_EN
      // Watchdog overrides the case above; an aborted load leaves coeff_loaded low
      if (state_q != IDLE && !wait_done) begin
        if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_q    <= 1'b1;
          load_coeff_q <= 1'b0;
          data_ready_q <= 1'b0;
          state_q      <= IDLE;
          tmo_cnt_q    <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
      end else begin
        tmo_cnt_q <= '0;
      end
`endif
    end
  end

  assign sample_ready    = !fifo_full;
  assign load_coeff      = load_coeff_q;
  assign fir_coefficient = fir_coef_q;
  assign data_ready      = data_ready_q;
  assign sample_data     = sample_data_q;
  assign coeff_loaded    = coeff_loaded_q;
  assign overrun         = overrun_q;
  assign state_dbg       = state_q;

endmodule
